// File: rtl/card_display_ctrl.sv
// Multi-channel seven-segment card display: per-channel face-down dash, timed reveal,
// and a shared blink phase for highlighting revealed cards. Segments are active-low, g..a.
module card_display_ctrl #(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned FLIP_CYCLES = 4,
    parameter int unsigned BLINK_HALF  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [NUM_CH-1:0]     load_en,
    input  logic [4*NUM_CH-1:0]   card_in,
    input  logic [NUM_CH-1:0]     blink_en,
    output logic [7*NUM_CH-1:0]   seg7_out,
    output logic                  busy
);

    localparam int unsigned FW        = (FLIP_CYCLES > 1) ? $clog2(FLIP_CYCLES) : 1;
    localparam int unsigned BW        = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned FLIP_INIT = (FLIP_CYCLES > 0) ? FLIP_CYCLES - 1 : 0;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FLIP  = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t              r_state     [NUM_CH];
    logic [FW-1:0]       r_cnt       [NUM_CH];
    logic [3:0]          r_card      [NUM_CH];
    logic [BW-1:0]       r_blink_cnt;
    logic                r_phase;
    logic [7*NUM_CH-1:0] r_seg;

    state_t              w_state_nxt [NUM_CH];
    logic [FW-1:0]       w_cnt_nxt   [NUM_CH];
    logic [3:0]          w_card_nxt  [NUM_CH];
    logic [BW-1:0]       w_blink_cnt_nxt;
    logic                w_phase_nxt;
    logic [7*NUM_CH-1:0] w_seg_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] code);
        case (code)
            4'd1:    f_decode = 7'b0001000;
            4'd2:    f_decode = 7'b0100100;
            4'd3:    f_decode = 7'b0110000;
            4'd4:    f_decode = 7'b0011001;
            4'd5:    f_decode = 7'b0010010;
            4'd6:    f_decode = 7'b0000010;
            4'd7:    f_decode = 7'b1111000;
            4'd8:    f_decode = 7'b0000000;
            4'd9:    f_decode = 7'b0010000;
            4'd10:   f_decode = 7'b1000000;
            4'd11:   f_decode = 7'b1110001;
            4'd12:   f_decode = 7'b0011000;
            4'd13:   f_decode = 7'b0001001;
            default: f_decode = SEG_BLANK;
        endcase
    endfunction

    // Shared blink timebase; free-running, untouched by clear
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
        w_phase_nxt     = r_phase;
        if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end
    end

    // Per-channel next state; output is decoded from the state being entered
    always_comb begin
        w_seg_nxt = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_card_nxt[i]  = r_card[i];
            if (clear) begin
                w_state_nxt[i] = ST_EMPTY;
            end else if (load_en[i]) begin
                if (card_in[4*i +: 4] >= 4'd1 && card_in[4*i +: 4] <= 4'd13) begin
                    w_card_nxt[i] = card_in[4*i +: 4];
                    if (FLIP_CYCLES > 0) begin
                        w_state_nxt[i] = ST_FLIP;
                        w_cnt_nxt[i]   = FW'(FLIP_INIT);
                    end else begin
                        w_state_nxt[i] = ST_SHOW;
                    end
                end else begin
                    w_state_nxt[i] = ST_EMPTY;
                end
            end else if (r_state[i] == ST_FLIP) begin
                if (r_cnt[i] == '0) begin
                    w_state_nxt[i] = ST_SHOW;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] - FW'(1);
                end
            end

            case (w_state_nxt[i])
                ST_FLIP: w_seg_nxt[7*i +: 7] = SEG_DASH;
                ST_SHOW: w_seg_nxt[7*i +: 7] = (blink_en[i] && w_phase_nxt) ? SEG_BLANK
                                                                          : f_decode(w_card_nxt[i]);
                default: w_seg_nxt[7*i +: 7] = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_seg       <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_EMPTY;
                r_cnt[i]   <= '0;
                r_card[i]  <= '0;
            end
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
            r_seg       <= w_seg_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
                r_card[i]  <= w_card_nxt[i];
            end
        end
    end

    // busy follows registered state directly
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_state[i] == ST_FLIP) busy = 1'b1;
        end
    end

    assign seg7_out = r_seg;

endmodule

// File: tb/tb_card_display_ctrl.sv
// Bench for card_display_ctrl: directed scenarios plus random traffic against a
// cycle-count based model (card age since load, blink phase from edges since reset).
module tb_card_display_ctrl;

    localparam int NCH = 6;
    localparam int FC  = 4;
    localparam int BH  = 8;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              clear = 1'b0;
    logic [NCH-1:0]    load_en = '0;
    logic [4*NCH-1:0]  card_in = '0;
    logic [NCH-1:0]    blink_en = '0;
    logic [7*NCH-1:0]  seg7_out;
    logic              busy;

    logic              clear0 = 1'b0;
    logic [NCH-1:0]    load_en0 = '0;
    logic [4*NCH-1:0]  card_in0 = '0;
    logic [NCH-1:0]    blink_en0 = '0;
    logic [7*NCH-1:0]  seg0;
    logic              busy0;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    card_display_ctrl #(.NUM_CH(NCH), .FLIP_CYCLES(FC), .BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load_en(load_en), .card_in(card_in),
        .blink_en(blink_en), .seg7_out(seg7_out), .busy(busy));

    card_display_ctrl #(.NUM_CH(NCH), .FLIP_CYCLES(0), .BLINK_HALF(BH)) dut0 (
        .clk(clk), .reset(reset), .clear(clear0), .load_en(load_en0), .card_in(card_in0),
        .blink_en(blink_en0), .seg7_out(seg0), .busy(busy0));

    // Reference model: edges since reset, and per channel the edge of its last valid load
    logic [6:0]  glyph [16];
    int unsigned m_e;
    logic        m_loaded [NCH];
    logic [3:0]  m_card   [NCH];
    int unsigned m_load_e [NCH];
    logic [NCH-1:0] m_be;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e  <= 0;
            m_be <= '0;
            for (int i = 0; i < NCH; i++) m_loaded[i] <= 1'b0;
        end else begin
            m_e  <= m_e + 1;
            m_be <= blink_en;
            for (int i = 0; i < NCH; i++) begin
                if (clear) m_loaded[i] <= 1'b0;
                else if (load_en[i]) begin
                    if (card_in[4*i +: 4] >= 1 && card_in[4*i +: 4] <= 13) begin
                        m_loaded[i] <= 1'b1;
                        m_card[i]   <= card_in[4*i +: 4];
                        m_load_e[i] <= m_e + 1;
                    end else m_loaded[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [6:0] exp_ch(input int i);
        int unsigned age;
        if (!m_loaded[i]) return BLANK;
        age = m_e - m_load_e[i];
        if (age < FC) return DASH;
        if (m_be[i] && ((m_e / BH) % 2 == 1)) return BLANK;
        return glyph[m_card[i]];
    endfunction

    function automatic logic exp_busy();
        for (int i = 0; i < NCH; i++)
            if (m_loaded[i] && (m_e - m_load_e[i]) < FC) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            vec++;
            if (seg7_out !== '1 || busy !== 1'b0) begin
                $display("FAIL reset_idle cyc %0d: seg=%h busy=%b, want all ones busy 0", c, seg7_out, busy);
                errs++;
            end
        end
        load_en[0] = 1'b1; card_in[3:0] = 4'd5;
        tick();
        load_en[0] = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        vec++;
        if (seg7_out[6:0] !== BLANK || busy !== 1'b0) begin
            $display("FAIL reset_midflip: seg0=%b busy=%b, want 1111111 busy 0", seg7_out[6:0], busy);
            errs++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_flip();
        card_in[3:0] = 4'd12; load_en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            load_en[0] = 1'b0;
            vec++;
            if (seg7_out[6:0] !== ((k < FC) ? DASH : 7'b0011000) || busy !== (k < FC)) begin
                $display("FAIL flip k=%0d: seg0=%b busy=%b", k, seg7_out[6:0], busy);
                errs++;
            end
        end
    endtask

    task automatic test_reload();
        card_in[7:4] = 4'd1; load_en[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            load_en[1] = 1'b0;
            if (k == 1) begin card_in[7:4] = 4'd13; load_en[1] = 1'b1; end
            vec++;
            if (seg7_out[13:7] !== ((k < 6) ? DASH : 7'b0001001)) begin
                $display("FAIL reload k=%0d: seg1=%b", k, seg7_out[13:7]);
                errs++;
            end
        end
    endtask

    task automatic test_blink();
        card_in[11:8] = 4'd7; load_en[2] = 1'b1;
        tick();
        load_en[2] = 1'b0;
        repeat (FC) tick();
        blink_en[2] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            vec++;
            if (seg7_out[20:14] !== exp_ch(2)) begin
                $display("FAIL blink cyc %0d: seg2=%b want %b", c, seg7_out[20:14], exp_ch(2));
                errs++;
            end
        end
        blink_en[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            vec++;
            if (seg7_out[20:14] !== 7'b1111000) begin
                $display("FAIL blink_off cyc %0d: seg2=%b want 1111000", c, seg7_out[20:14]);
                errs++;
            end
        end
    endtask

    task automatic test_invalid();
        card_in[15:12] = 4'd9; card_in[19:16] = 4'd11; card_in[23:20] = 4'd3;
        load_en[5:3] = 3'b111;
        tick();
        load_en = '0;
        repeat (FC + 1) tick();
        card_in[15:12] = 4'd0; card_in[19:16] = 4'd15;
        load_en[4:3] = 2'b11;
        tick();
        load_en = '0;
        for (int c = 0; c < 5; c++) begin
            vec++;
            if (seg7_out[34:21] !== {BLANK, BLANK} || seg7_out[41:35] !== 7'b0110000) begin
                $display("FAIL invalid cyc %0d: seg4..3=%h seg5=%b", c, seg7_out[34:21], seg7_out[41:35]);
                errs++;
            end
            tick();
        end
        clear = 1'b1; load_en[5] = 1'b1; card_in[23:20] = 4'd8;
        tick();
        clear = 1'b0; load_en = '0;
        vec++;
        if (seg7_out[41:35] !== BLANK || busy !== 1'b0) begin
            $display("FAIL clear_prio: seg5=%b busy=%b want blank busy 0", seg7_out[41:35], busy);
            errs++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clear    = ($urandom_range(0, 29) == 0);
            load_en  = NCH'($urandom & $urandom);
            card_in  = (4*NCH)'($urandom);
            if ($urandom_range(0, 9) == 0) blink_en = NCH'($urandom);
            tick();
            for (int i = 0; i < NCH; i++) begin
                vec++;
                if (seg7_out[7*i +: 7] !== exp_ch(i)) begin
                    $display("FAIL random cyc %0d ch%0d: seg=%b want %b", c, i, seg7_out[7*i +: 7], exp_ch(i));
                    errs++;
                end
            end
            vec++;
            if (busy !== exp_busy()) begin
                $display("FAIL random_busy cyc %0d: busy=%b want %b", c, busy, exp_busy());
                errs++;
            end
        end
        clear = 1'b0; load_en = '0; blink_en = '0;
    endtask

    task automatic test_noflip();
        logic [7*NCH-1:0] want;
        for (int i = 0; i < NCH; i++) begin
            card_in0[4*i +: 4] = 4'(i + 1);
            want[7*i +: 7] = glyph[i + 1];
        end
        load_en0 = '1;
        vec++;
        if (busy0 !== 1'b0) begin
            $display("FAIL noflip_busy_pre: busy=%b want 0", busy0);
            errs++;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            load_en0 = '0;
            vec++;
            if (seg0 !== want || busy0 !== 1'b0) begin
                $display("FAIL noflip cyc %0d: seg=%h busy=%b want %h busy 0", c, seg0, busy0, want);
                errs++;
            end
        end
    endtask

    initial begin
        glyph[0]  = BLANK;      glyph[1]  = 7'b0001000; glyph[2]  = 7'b0100100;
        glyph[3]  = 7'b0110000; glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010;
        glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000; glyph[8]  = 7'b0000000;
        glyph[9]  = 7'b0010000; glyph[10] = 7'b1000000; glyph[11] = 7'b1110001;
        glyph[12] = 7'b0011000; glyph[13] = 7'b0001001; glyph[14] = BLANK;
        glyph[15] = BLANK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_flip();
        test_reload();
        test_blink();
        test_invalid();
        test_random();
        test_noflip();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
